// File: rtl/gcd.sv
// Iterative GCD engine: Euclid by repeated subtraction, one step per clock.
// Operands are captured on start; result/done are registered and held until the next start or reset.
module gcd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] x, y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (start) begin
      // start wins from any state; a job in flight is simply discarded
      x     <= a;
      y     <= b;
      done  <= 1'b0;
      state <= BUSY;
    end else begin
      case (state)
        BUSY: begin
          if (x == '0) begin
            result <= y;
            done   <= 1'b1;
            state  <= DONE;
          end else if (y == '0) begin
            result <= x;
            done   <= 1'b1;
            state  <= DONE;
          end else if (x == y) begin
            result <= x;
            done   <= 1'b1;
            state  <= DONE;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd.sv
// Directed bench for gcd: one task per scenario, expected values computed by hand.
module tb_gcd;
  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a, b;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             done;

  int total  = 0;
  int passed = 0;

  gcd #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .start(start),
    .result(result), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands with a one-cycle start; returns #1 after the start edge.
  task automatic start_job(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done rises or the bound expires.
  task automatic wait_done(input int bound, output int edges);
    edges = 0;
    while (!done && edges < bound) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    total++;
    if (result !== 8'd0 || done !== 1'b0)
      $display("FAIL reset: result=%0d done=%b, want result=0 done=0", result, done);
    else passed++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic;
    int e;
    start_job(8'd15, 8'd5);
    wait_done(300, e);
    total++;
    if (done !== 1'b1 || result !== 8'd5 || e != 3)
      $display("FAIL basic_15_5: done=%b result=%0d edges=%0d, want 1/5/3", done, result, e);
    else passed++;
    start_job(8'd15, 8'd6);
    wait_done(300, e);
    total++;
    if (done !== 1'b1 || result !== 8'd3 || e != 4)
      $display("FAIL basic_15_6: done=%b result=%0d edges=%0d, want 1/3/4", done, result, e);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int e;
    start_job(8'd123, 8'd33);
    total++;
    if (done !== 1'b0) $display("FAIL b2b_123_33_start: done=%b, want 0", done);
    else passed++;
    wait_done(300, e);
    total++;
    if (done !== 1'b1 || result !== 8'd3 || e != 9)
      $display("FAIL b2b_123_33: done=%b result=%0d edges=%0d, want 1/3/9", done, result, e);
    else passed++;
    start_job(8'd124, 8'd33);
    total++;
    if (done !== 1'b0) $display("FAIL b2b_124_33_start: done=%b, want 0", done);
    else passed++;
    wait_done(300, e);
    total++;
    if (done !== 1'b1 || result !== 8'd1)
      $display("FAIL b2b_124_33: done=%b result=%0d, want 1/1", done, result);
    else passed++;
  endtask

  task automatic test_zero_equal;
    logic [WIDTH-1:0] av [4] = '{8'd0, 8'd9, 8'd0, 8'd42};
    logic [WIDTH-1:0] bv [4] = '{8'd7, 8'd0, 8'd0, 8'd42};
    logic [WIDTH-1:0] ex [4] = '{8'd7, 8'd9, 8'd0, 8'd42};
    int e;
    for (int i = 0; i < 4; i++) begin
      start_job(av[i], bv[i]);
      wait_done(300, e);
      total++;
      if (done !== 1'b1 || result !== ex[i] || e != 1)
        $display("FAIL zero_equal(%0d,%0d): done=%b result=%0d edges=%0d, want 1/%0d/1",
                 av[i], bv[i], done, result, e, ex[i]);
      else passed++;
    end
  endtask

  task automatic test_worst_hold;
    int e;
    start_job(8'd255, 8'd1);
    wait_done(256, e);
    total++;
    if (done !== 1'b1 || result !== 8'd1 || e != 255)
      $display("FAIL worst_255_1: done=%b result=%0d edges=%0d, want 1/1/255", done, result, e);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 8'(i * 37 + 4); b = 8'(i * 11 + 2);
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || result !== 8'd1)
        $display("FAIL hold_%0d: done=%b result=%0d, want 1/1", i, done, result);
      else passed++;
    end
  endtask

  task automatic test_restart;
    int e;
    logic seen_done;
    start_job(8'd200, 8'd3);
    seen_done = done;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    start_job(8'd48, 8'd18);
    seen_done |= done;
    total++;
    if (seen_done !== 1'b0) $display("FAIL restart_no_early_done: saw done=%b, want 0", seen_done);
    else passed++;
    wait_done(300, e);
    total++;
    if (done !== 1'b1 || result !== 8'd6 || e != 5)
      $display("FAIL restart_48_18: done=%b result=%0d edges=%0d, want 1/6/5", done, result, e);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int e;
    logic seen_done;
    start_job(8'd255, 8'd2);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (result !== 8'd0 || done !== 1'b0)
      $display("FAIL reset_mid: result=%0d done=%b, want 0/0", result, done);
    else passed++;
    @(negedge clk); reset = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin @(posedge clk); #1; seen_done |= done; end
    total++;
    if (seen_done !== 1'b0) $display("FAIL reset_mid_aborted: saw done=%b, want 0", seen_done);
    else passed++;
    start_job(8'd12, 8'd8);
    wait_done(300, e);
    total++;
    if (done !== 1'b1 || result !== 8'd4 || e != 3)
      $display("FAIL after_reset_12_8: done=%b result=%0d edges=%0d, want 1/4/3", done, result, e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_equal();
    test_worst_hold();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
